// File: rtl/shiftreg_sequencer.sv
// shiftreg_sequencer
//   Sequences one parallel-in/serial-out shift register transaction:
//   accept a start request, latch the word, pulse a one-cycle parallel load,
//   issue WIDTH shift ticks (one every DIVIDE clocks), then capture the
//   register contents as the received word and pulse done.
//
// Ports
//   clk          : system clock, all state on rising edge
//   resetn       : asynchronous active-low reset
//   start        : transaction request, only honoured while idle
//   txdata       : word to load, latched when start is accepted
//   parallelout  : current shift register contents
//   parallelload : one-cycle load strobe to the shift register
//   paralleldata : latched txdata presented to the shift register
//   shiftedge    : one-cycle shift enable to the shift register
//   busy         : high from the load cycle through the finish cycle
//   done         : one-cycle completion pulse, coincident with valid rxdata
//   rxdata       : parallelout captured at the end of the transaction
//   bitcount     : shift ticks issued in the current/last transaction
module shiftreg_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIVIDE = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [WIDTH-1:0]           txdata,
  input  logic [WIDTH-1:0]           parallelout,
  output logic                       parallelload,
  output logic [WIDTH-1:0]           paralleldata,
  output logic                       shiftedge,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           rxdata,
  output logic [$clog2(WIDTH+1)-1:0] bitcount
);

  localparam int BCW = $clog2(WIDTH + 1);
  // A one-clock tick still needs a 1-bit divider so the declarations stay legal.
  localparam int DW  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(DIVIDE - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(WIDTH - 1);
  // With DIVIDE==1 every SHIFT cycle is a tick, so the strobe re-arms on its own.
  localparam logic           SE_EVERY = (DIVIDE == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t           state_r;
  logic [DW-1:0]    divider_r;
  logic [DW-1:0]    divider_inc_s;
  logic [BCW-1:0]   bitcount_r;
  logic [BCW-1:0]   bitcount_inc_s;
  logic             parallelload_r;
  logic [WIDTH-1:0] paralleldata_r;
  logic             shiftedge_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] rxdata_r;

  // Incremented counter values used by the state machine.
  always_comb begin
    divider_inc_s  = divider_r + DW'(1);
    bitcount_inc_s = bitcount_r + BCW'(1);
  end

  // Transaction state machine; every output strobe is registered one edge
  // ahead so it lines up with the cycle it describes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      divider_r      <= '0;
      bitcount_r     <= '0;
      parallelload_r <= 1'b0;
      paralleldata_r <= '0;
      shiftedge_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      rxdata_r       <= '0;
    end else begin
      parallelload_r <= 1'b0;
      shiftedge_r    <= 1'b0;
      done_r         <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            paralleldata_r <= txdata;
            parallelload_r <= 1'b1;
            busy_r         <= 1'b1;
            state_r        <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          divider_r   <= '0;
          bitcount_r  <= '0;
          shiftedge_r <= SE_EVERY;
          state_r     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (divider_r == DIV_LAST) begin
            // This cycle carried a shift tick.
            divider_r  <= '0;
            bitcount_r <= bitcount_inc_s;
            if (bitcount_r == BC_LAST) begin
              state_r <= ST_FINISH;
            end else begin
              shiftedge_r <= SE_EVERY;
            end
          end else begin
            divider_r   <= divider_inc_s;
            shiftedge_r <= (divider_inc_s == DIV_LAST);
          end
        end
        ST_FINISH: begin
          // parallelout already reflects the final shift here.
          rxdata_r <= parallelout;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign parallelload = parallelload_r;
  assign paralleldata = paralleldata_r;
  assign shiftedge    = shiftedge_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign rxdata       = rxdata_r;
  assign bitcount     = bitcount_r;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Bench for shiftreg_sequencer: instance 0 uses DIVIDE=4, instance 1 DIVIDE=1,
// each driving a rotate-left shift register model. Stimulus pushes the expected
// transaction timeline into a queue; a negedge monitor compares every strobe
// each cycle and pops the entry when the transaction completes.
module tb_shiftreg_sequencer;

  localparam int W  = 8;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;

  always #5 clk = ~clk;

  logic         start_s        [NI];
  logic [W-1:0] txdata_s       [NI];
  logic [W-1:0] parallelout_s  [NI];
  logic         parallelload_s [NI];
  logic [W-1:0] paralleldata_s [NI];
  logic         shiftedge_s    [NI];
  logic         busy_s         [NI];
  logic         done_s         [NI];
  logic [W-1:0] rxdata_s       [NI];
  logic [3:0]   bitcount_s     [NI];
  logic [W-1:0] sr_r           [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shiftreg_sequencer #(.WIDTH(W), .DIVIDE((g == 0) ? 4 : 1)) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start_s[g]),
      .txdata       (txdata_s[g]),
      .parallelout  (parallelout_s[g]),
      .parallelload (parallelload_s[g]),
      .paralleldata (paralleldata_s[g]),
      .shiftedge    (shiftedge_s[g]),
      .busy         (busy_s[g]),
      .done         (done_s[g]),
      .rxdata       (rxdata_s[g]),
      .bitcount     (bitcount_s[g])
    );
    assign parallelout_s[g] = sr_r[g];
  end

  typedef struct {
    int           inst;
    int           load_cyc;
    int           done_cyc;
    logic [W-1:0] tx;
    logic [W-1:0] rx;
  } txn_t;

  txn_t exp_q[$];
  int   next_free [NI];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Received word after W left rotations of the loaded word.
  function automatic logic [W-1:0] ref_rx(logic [W-1:0] tx);
    logic [W-1:0] v;
    v = tx;
    for (int k = 0; k < W; k++) v = {v[W-2:0], v[W-1]};
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Shift register environment model: load has priority, shift rotates left.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (parallelload_s[i]) sr_r[i] <= paralleldata_s[i];
      else if (shiftedge_s[i]) sr_r[i] <= {sr_r[i][W-2:0], sr_r[i][W-1]};
    end
  end

  // Monitor: per-cycle comparison of all strobes against the queued timeline.
  always @(negedge clk) begin
    txn_t e;
    bit   have;
    bit   pop;
    int   d;
    logic epl, ese, ebusy, edone;
    if (resetn) begin
      pop = 1'b0;
      for (int i = 0; i < NI; i++) begin
        have = (exp_q.size() > 0) && (exp_q[0].inst == i);
        if (have) e = exp_q[0];
        d     = div_of(i);
        epl   = have && (cyc == e.load_cyc);
        ese   = have && (cyc > e.load_cyc) && (cyc <= e.load_cyc + W * d) &&
                (((cyc - e.load_cyc) % d) == 0);
        ebusy = have && (cyc >= e.load_cyc) && (cyc < e.done_cyc);
        edone = have && (cyc == e.done_cyc);
        check($sformatf("parallelload[%0d]", i), 32'(parallelload_s[i]), 32'(epl));
        check($sformatf("shiftedge[%0d]", i), 32'(shiftedge_s[i]), 32'(ese));
        check($sformatf("busy[%0d]", i), 32'(busy_s[i]), 32'(ebusy));
        check($sformatf("done[%0d]", i), 32'(done_s[i]), 32'(edone));
        if (ebusy) check($sformatf("paralleldata[%0d]", i), 32'(paralleldata_s[i]), 32'(e.tx));
        if (edone) begin
          check($sformatf("rxdata[%0d]", i), 32'(rxdata_s[i]), 32'(e.rx));
          check($sformatf("bitcount[%0d]", i), 32'(bitcount_s[i]), 32'(W));
          pop = 1'b1;
        end
      end
      if (pop) void'(exp_q.pop_front());
    end
  end

  // Drive one cycle of stimulus for instance i (other instance idle).
  task automatic step(int i, logic st, logic [W-1:0] tx);
    int d;
    @(posedge clk);
    #1;
    d = div_of(i);
    for (int j = 0; j < NI; j++) start_s[j] = 1'b0;
    start_s[i]  = st;
    txdata_s[i] = tx;
    if (st && resetn && (cyc >= next_free[i])) begin
      exp_q.push_back('{inst: i, load_cyc: cyc + 1, done_cyc: cyc + W * d + 3,
                        tx: tx, rx: ref_rx(tx)});
      next_free[i] = cyc + W * d + 3;
    end
  endtask

  task automatic idle(int i, int n);
    repeat (n) step(i, 1'b0, 8'($urandom));
  endtask

  task automatic check_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s.parallelload[%0d]", tag, i), 32'(parallelload_s[i]), 32'd0);
      check($sformatf("%s.shiftedge[%0d]", tag, i), 32'(shiftedge_s[i]), 32'd0);
      check($sformatf("%s.busy[%0d]", tag, i), 32'(busy_s[i]), 32'd0);
      check($sformatf("%s.done[%0d]", tag, i), 32'(done_s[i]), 32'd0);
      check($sformatf("%s.paralleldata[%0d]", tag, i), 32'(paralleldata_s[i]), 32'd0);
      check($sformatf("%s.rxdata[%0d]", tag, i), 32'(rxdata_s[i]), 32'd0);
      check($sformatf("%s.bitcount[%0d]", tag, i), 32'(bitcount_s[i]), 32'd0);
    end
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic do_reset(string tag);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    for (int j = 0; j < NI; j++) start_s[j] = 1'b0;
    #1;
    check_zero(tag);
    exp_q.delete();
    for (int j = 0; j < NI; j++) next_free[j] = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    for (int j = 0; j < NI; j++) begin
      start_s[j]   = 1'b0;
      txdata_s[j]  = '0;
      next_free[j] = 0;
      sr_r[j]      = '0;
    end
    @(posedge clk);
    #1;
    check_zero("por");
    resetn = 1'b1;

    // Basic transaction
    step(0, 1'b1, 8'hA5);
    idle(0, 40);

    // Start while busy is ignored
    step(0, 1'b1, 8'hA5);
    idle(0, 9);
    step(0, 1'b1, 8'h3C);
    idle(0, 40);

    // Reset mid-shift, then a clean transaction
    step(0, 1'b1, 8'h5A);
    idle(0, 19);
    do_reset("midshift");
    step(0, 1'b1, 8'h0F);
    idle(0, 40);

    // Continuous start: three back-to-back transactions
    repeat (71) step(0, 1'b1, 8'($urandom));
    idle(0, 40);

    // Random traffic
    repeat (300) step(0, ($urandom_range(0, 9) == 0), 8'($urandom));
    idle(0, 40);

    // DIVIDE=1 instance
    step(1, 1'b1, 8'h81);
    idle(1, 15);
    repeat (33) step(1, 1'b1, 8'($urandom));
    repeat (100) step(1, ($urandom_range(0, 3) == 0), 8'($urandom));
    idle(1, 20);

    check("drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shiftreg_sequencer.md
Name: shiftreg_sequencer

Overview:
Controller that sequences the parallel-in/serial-out shift register datapath for one transaction. On a start pulse from the conditioned button path it latches a word and issues a one-cycle parallel load. It then issues WIDTH divided shift-enable ticks and captures the register's parallel output as the received word. It replaces ad-hoc button/switch sequencing with a deterministic, handshaked transaction.

Parameters:
WIDTH, 8, shift register width in bits; also the number of shift ticks per transaction
DIVIDE, 4, clk cycles per shift tick; legal range >=1

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  transaction request, sampled only in IDLE
txdata  input  WIDTH  word to load; latched on the edge where start is accepted
parallelout  input  WIDTH  current shift register contents
parallelload  output  1  one-cycle load strobe to shift register
paralleldata  output  WIDTH  latched txdata driven to shift register load input
shiftedge  output  1  one-cycle shift enable to shift register
busy  output  1  high from LOAD through FINISH inclusive
done  output  1  one-cycle completion pulse
rxdata  output  WIDTH  parallelout captured at end of transaction
bitcount  output  $clog2(WIDTH+1)  shift ticks issued in current/last transaction

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; divider=0; parallelload, shiftedge, busy, done=0; paralleldata, rxdata, bitcount=0. Takes effect immediately, including mid-transaction. No done is produced for an aborted transaction.
- All outputs registered or decoded from registered state only. No combinational path from start to any output.
- States: IDLE, LOAD, SHIFT, FINISH.
- IDLE: if start=1 at an edge, latch txdata into paralleldata and go to LOAD; otherwise stay.
- LOAD (exactly 1 cycle): parallelload=1, busy=1. Next: SHIFT with divider=0 and bitcount=0.
- SHIFT: divider counts 0..DIVIDE-1 and wraps. shiftedge=1 in the cycles where divider==DIVIDE-1; bitcount increments at the end of each such cycle. After the WIDTH-th shiftedge cycle, go to FINISH. SHIFT lasts exactly WIDTH*DIVIDE cycles.
- FINISH (1 cycle): busy=1. At its closing edge: rxdata<=parallelout (post-final-shift value), done<=1, state<=IDLE.
- done is high for exactly the first IDLE cycle after FINISH, coincident with valid rxdata; busy=0 in that cycle.
- Timeline, start accepted at end of cycle 0:
  - LOAD in cycle 1.
  - shiftedge in cycles 1+k*DIVIDE, k=1..WIDTH.
  - FINISH in cycle 2+WIDTH*DIVIDE.
  - done in cycle 3+WIDTH*DIVIDE.
- start while busy=1 is ignored, not queued; txdata changes while busy have no effect.
- start held high continuously gives back-to-back transactions with period WIDTH*DIVIDE+3 cycles. The done cycle is itself the IDLE cycle that accepts the next start.
- bitcount holds WIDTH after completion until the next LOAD clears it.
- paralleldata and rxdata hold their values between transactions.

Test Plan:
- Reset: resetn=0 at arbitrary time -> all outputs 0 immediately, before the next clk edge; state IDLE after release.
- Basic (WIDTH=8, DIVIDE=4; bench shift register model rotates left on shiftedge): txdata=8'hA5, start pulse in cycle 0 -> parallelload in cycle 1 only; shiftedge in cycles 5,9,...,33 (8 pulses); busy cycles 1-34; done in cycle 35 with rxdata=8'hA5, bitcount=8.
- Start while busy: repeat Basic, plus start=1 with txdata=8'h3C in cycle 10 -> no second parallelload, exactly 8 shiftedges, rxdata=8'hA5, paralleldata stays 8'hA5.
- Reset mid-shift: resetn=0 in cycle 20 -> busy/shiftedge drop at once, no done. After release, start with txdata=8'h0F -> normal transaction, rxdata=8'h0F, bitcount=8.
- Continuous start: start held 1 from cycle 0 -> LOAD in cycles 1, 36, 71; done in cycles 35, 70; each done cycle has busy=0.
- DIVIDE=1 instance: txdata=8'h81, start in cycle 0 -> shiftedge in consecutive cycles 2-9, FINISH in cycle 10, done in cycle 11 with rxdata=8'h81.
